keccak_pi_inv_lane_stream: RTL and testbench

KECCAK_PI_INV_LANE_STREAM -- requirements
Module: keccak_pi_inv_lane_stream

---
 rtl/keccak_pi_inv_lane_stream.sv | 154 +++++++++++++++
 tb/tb_keccak_pi_inv_lane_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pi_inv_lane_stream.sv
// Streaming inverse of the Keccak Pi step: buffers 25 Pi-permuted lanes,
// then emits them in original (5*Y+X) order using a constant slot table.
module keccak_pi_inv_lane_stream #(
    parameter int unsigned LANE_W    = 64,
    parameter int unsigned NUM_LANES = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_valid,
    output logic              i_ready,
    output logic [LANE_W-1:0] o_lane,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LANES - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              i_ready_q, i_ready_d;
    logic              o_valid_q, o_valid_d;
    logic              o_last_q, o_last_d;
    logic [LANE_W-1:0] o_lane_q, o_lane_d;
    logic [LANE_W-1:0] lane_buf_q [NUM_LANES];

    logic              wr_en;
    logic              rd_en;
    logic [CNT_W-1:0]  src_idx;

    // Output index 5*Y+X reads buffer slot 5*((2X+3Y) mod 5)+Y.
    function automatic logic [CNT_W-1:0] src_slot(input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] s;
        case (idx)
            5'd0:    s = 5'd0;
            5'd1:    s = 5'd10;
            5'd2:    s = 5'd20;
            5'd3:    s = 5'd5;
            5'd4:    s = 5'd15;
            5'd5:    s = 5'd16;
            5'd6:    s = 5'd1;
            5'd7:    s = 5'd11;
            5'd8:    s = 5'd21;
            5'd9:    s = 5'd6;
            5'd10:   s = 5'd7;
            5'd11:   s = 5'd17;
            5'd12:   s = 5'd2;
            5'd13:   s = 5'd12;
            5'd14:   s = 5'd22;
            5'd15:   s = 5'd23;
            5'd16:   s = 5'd8;
            5'd17:   s = 5'd18;
            5'd18:   s = 5'd3;
            5'd19:   s = 5'd13;
            5'd20:   s = 5'd14;
            5'd21:   s = 5'd24;
            5'd22:   s = 5'd9;
            5'd23:   s = 5'd19;
            5'd24:   s = 5'd4;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    assign wr_en = i_valid && i_ready_q;
    assign rd_en = o_valid_q && o_ready;

    // Next-state, counters and registered output values.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        o_lane_d = o_lane_q;
        src_idx  = '0;

        case (state_q)
            FILL: begin
                if (wr_en) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d  = DRAIN;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (rd_en) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d  = FILL;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Forward the lane being written this cycle if it is the one selected.
        src_idx = src_slot(rd_cnt_d);
        if (wr_en && (wr_cnt_q == src_idx)) begin
            o_lane_d = i_lane;
        end else begin
            o_lane_d = lane_buf_q[src_idx];
        end

        i_ready_d = (state_d == FILL);
        o_valid_d = (state_d == DRAIN);
        o_last_d  = (state_d == DRAIN) && (rd_cnt_d == LAST_IDX);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
        end
    end

    // Lane storage and output data carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            lane_buf_q[wr_cnt_q] <= i_lane;
        end
        o_lane_q <= o_lane_d;
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_lane  = o_lane_q;

endmodule

// File: tb/tb_keccak_pi_inv_lane_stream.sv
// Directed/table-driven bench for keccak_pi_inv_lane_stream.
module tb_keccak_pi_inv_lane_stream;

    typedef logic [63:0] lane_t;
    typedef struct {
        lane_t lane_in;
        lane_t exp_out;
        logic  exp_last;
    } vec_t;

    logic  clk;
    logic  rst;
    lane_t i_lane;
    logic  i_valid;
    logic  i_ready;
    lane_t o_lane;
    logic  o_valid;
    logic  o_ready;
    logic  o_last;

    int n_cmp;
    int n_err;

    lane_t st_in  [25];
    lane_t orig   [25];
    lane_t got    [25];
    logic  got_last [25];

    keccak_pi_inv_lane_stream #(.LANE_W(64), .NUM_LANES(25)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_lane  (i_lane),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_lane  (o_lane),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input lane_t act, input lane_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push st_in[0..n-1]; optional random i_valid gaps.
    task automatic fill(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) begin
                    i_valid = 1'b0;
                    tick();
                end
            end
            i_valid = 1'b1;
            i_lane  = st_in[i];
            chk($sformatf("fill_ready[%0d]", i), 64'(i_ready), 64'd1);
            tick();
        end
        i_valid = 1'b0;
        i_lane  = '0;
        if (n == 25) begin
            chk("latency_o_valid", 64'(o_valid), 64'd1);
        end
    endtask

    // Collect n output transfers; optional random o_ready stalls.
    task automatic drain(input int n, input bit stall);
        int    rd;
        int    cyc;
        bit    xfer;
        lane_t cap_lane;
        logic  cap_last;
        rd  = 0;
        cyc = 0;
        while (rd < n && cyc < 1000) begin
            o_ready  = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            chk("drain_o_valid", 64'(o_valid), 64'd1);
            chk("drain_i_ready", 64'(i_ready), 64'd0);
            xfer     = o_ready && o_valid;
            cap_lane = o_lane;
            cap_last = o_last;
            tick();
            cyc++;
            if (xfer) begin
                got[rd]      = cap_lane;
                got_last[rd] = cap_last;
                chk($sformatf("o_last[%0d]", rd), 64'(cap_last), 64'(rd == 24));
                rd++;
            end else begin
                chk("stall_lane", o_lane, cap_lane);
                chk("stall_last", 64'(o_last), 64'(cap_last));
            end
        end
        o_ready = 1'b0;
        if (rd < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d lanes expected %0d", rd, n);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_i_ready"}, 64'(i_ready), 64'd1);
        chk({name, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({name, "_o_last"},  64'(o_last),  64'd0);
    endtask

    // Forward Pi: A'[x,y] = A[(x+3y) mod 5, x], lane index 5*y+x.
    task automatic apply_pi();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                st_in[5*y+x] = orig[5*x + ((x + 3*y) % 5)];
    endtask

    task automatic rand_orig();
        for (int i = 0; i < 25; i++) orig[i] = {$urandom, $urandom};
    endtask

    task automatic compare_orig(input string name);
        for (int i = 0; i < 25; i++)
            chk($sformatf("%s[%0d]", name, i), got[i], orig[i]);
    endtask

    vec_t tbl [25];
    int   exp_seq [25];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_lane  = '0;
        o_ready = 1'b0;

        exp_seq = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                    23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
        for (int i = 0; i < 25; i++) begin
            tbl[i].lane_in  = 64'(i);
            tbl[i].exp_out  = 64'(exp_seq[i]);
            tbl[i].exp_last = (i == 24);
        end

        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Lanes k=0..24 with o_ready held high.
        for (int i = 0; i < 25; i++) st_in[i] = tbl[i].lane_in;
        fill(25, 1'b0);
        drain(25, 1'b0);
        for (int i = 0; i < 25; i++) begin
            chk($sformatf("tbl_lane[%0d]", i), got[i], tbl[i].exp_out);
            chk($sformatf("tbl_last[%0d]", i), 64'(got_last[i]), 64'(tbl[i].exp_last));
        end
        check_idle("after_drain");

        // Random states round-tripped through Pi; some with gaps, some stalled.
        for (int v = 0; v < 100; v++) begin
            rand_orig();
            apply_pi();
            fill(25, (v % 3) == 1);
            drain(25, (v % 3) == 2);
            compare_orig($sformatf("rt%0d", v));
        end

        // Reset after 12 lanes, then a fresh state.
        for (int i = 0; i < 25; i++) st_in[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        fill(12, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_fill_rst");
        rand_orig();
        apply_pi();
        fill(25, 1'b0);
        drain(25, 1'b0);
        compare_orig("after_fill_rst");

        // Reset in DRAIN at rd_cnt=7.
        rand_orig();
        apply_pi();
        fill(25, 1'b0);
        drain(7, 1'b0);
        rst     = 1'b1;
        o_ready = 1'b1;
        tick();
        rst     = 1'b0;
        o_ready = 1'b0;
        check_idle("mid_drain_rst");
        rand_orig();
        apply_pi();
        fill(25, 1'b0);
        drain(25, 1'b1);
        compare_orig("after_drain_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
